block_reducer: RTL

- Downstream consumer of the multiplier's block-read port.
- On `start`, pulses `EN_blockRead` once, then collects up to 2^LOGDEPTH beats qualified by `VALID_memVal`.
- Computes the unsigned sum, unsigned maximum and beat count of the collected data.
- Presents the result on a valid/ready handshake to the next stage; a stall timer terminates collection if the producer stops delivering.

---
 rtl/block_reducer_pkg.sv | 16 +
 rtl/stall_timer.sv | 36 +++
 rtl/block_reducer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/block_reducer_pkg.sv
// Shared types and helpers for the block reducer: FSM state encoding and depth derivation.
package block_reducer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } reducer_state_t;

    // Number of beats in one block for a given log2 depth.
    function automatic int unsigned depth_of(input int unsigned logdepth);
        return 32'd1 << logdepth;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive idle ticks; flags expiry on the tick that completes TIMEOUT idle cycles.
module stall_timer #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = tick && !clear && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_reducer.sv
// Requests one block from the multiplier, reduces its beats to sum/max/count and hands the
// result downstream on a valid/ready handshake; a stall timer bounds collection.
module block_reducer
    import block_reducer_pkg::*;
#(
    parameter int unsigned LOGDEPTH = 6,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH+LOGDEPTH-1:0] res_sum,
    output logic [WIDTH-1:0]          res_max,
    output logic [LOGDEPTH:0]         res_count,
    output logic                      res_timeout
);

    localparam int unsigned DEPTH = depth_of(LOGDEPTH);
    localparam int unsigned SW    = WIDTH + LOGDEPTH;
    localparam int unsigned CNTW  = LOGDEPTH + 1;
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

    reducer_state_t state_q, state_d;

    logic [SW-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNTW-1:0]  count_q, count_d, count_inc;
    logic             timeout_q, timeout_d;

    logic timer_clear, timer_tick, timer_expired;

    assign count_inc   = count_q + CNTW'(1);
    assign timer_clear = (state_q == REQ) || ((state_q == COLLECT) && VALID_memVal);
    assign timer_tick  = (state_q == COLLECT) && !VALID_memVal;

    stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     state_d = COLLECT;
            COLLECT: begin
                if (VALID_memVal && (count_inc == DEPTH_CNT)) begin
                    state_d = DONE;
                end else if (timer_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        EN_blockRead = (state_q == REQ);
        res_valid    = (state_q == DONE);
    end

    // Result registers only move in REQ (clear) and COLLECT, so they hold through DONE.
    always_comb begin
        sum_d     = sum_q;
        max_d     = max_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        if (state_q == REQ) begin
            sum_d     = '0;
            max_d     = '0;
            count_d   = '0;
            timeout_d = 1'b0;
        end else if (state_q == COLLECT) begin
            if (VALID_memVal) begin
                sum_d   = sum_q + {{LOGDEPTH{1'b0}}, memVal_data};
                max_d   = (memVal_data > max_q) ? memVal_data : max_q;
                count_d = count_inc;
            end else if (timer_expired) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            max_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            max_q     <= max_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign res_sum     = sum_q;
    assign res_max     = max_q;
    assign res_count   = count_q;
    assign res_timeout = timeout_q;

endmodule
